// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if
// Request/ready handshake between the data cache controller and the slower
// backing data memory.
//
// Signals:
//   mem_req    cache -> memory   request outstanding
//   mem_we     cache -> memory   1 = write, 0 = read (valid while mem_req)
//   mem_addr   cache -> memory   word address, bits [1:0] always 0
//   mem_wdata  cache -> memory   write data
//   mem_rdata  memory -> cache   read data, valid while mem_ready is high
//   mem_ready  memory -> cache   request completes at this clock edge
//
// Modports: master (cache side), slave (memory side).
interface dcache_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller that
// sits between the pipeline's Memory stage and the backing data memory.
// One 32-bit word per line. Load hits complete with no stall; load misses and
// all stores stall the pipeline while a request runs on the memory handshake,
// followed by a single DONE cycle in which the M-stage instruction retires.
//
// Parameters:
//   LINES       number of lines (power of two, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   mem         dcache_ctrl_if.master, backing-memory request/ready handshake
//   memtoregm   M-stage load present
//   memwritem   M-stage store present (wins when both are high)
//   aluoutm     M-stage byte address (bits [1:0] ignored)
//   writedatam  M-stage store data
//   rdm         load data to the datapath
//   hitcount    load hits evaluated in IDLE   (only with DCACHE_STATS_EN)
//   misscount   IDLE->FILL transitions        (only with DCACHE_STATS_EN)
//   stallm      freezes F, D, E and M stages while high
//
// Optional feature: define DCACHE_STATS_EN to add the hitcount/misscount
// statistics counters and their output ports.
module dcache_ctrl #(
    parameter int LINES = 16
) (
    input  logic          clk,
    input  logic          reset,
    dcache_ctrl_if.master mem,
    input  logic          memtoregm,
    input  logic          memwritem,
    input  logic [31:0]   aluoutm,
    input  logic [31:0]   writedatam,
    output logic [31:0]   rdm,
`ifdef DCACHE_STATS_EN
    output logic [31:0]   hitcount,
    output logic [31:0]   misscount,
`endif
    output logic          stallm
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t state;

    logic             valid [LINES];
    logic [TAG_W-1:0] tags  [LINES];
    logic [31:0]      data  [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] lat_idx;
    logic [TAG_W-1:0] lat_tag;
    logic             hit;
    logic             is_load;
    logic             is_store;
    logic             store_hit;
    logic             unused_addr_bits;

    assign idx      = aluoutm[IDX_W+1:2];
    assign tag      = aluoutm[31:IDX_W+2];
    assign hit      = valid[idx] && (tags[idx] == tag);
    assign is_store = memwritem;
    assign is_load  = memtoregm && !memwritem;

    // The outstanding access is described entirely by the latched request
    // registers, so the fill/write target comes from mem_addr rather than
    // from aluoutm.
    assign lat_idx  = mem.mem_addr[IDX_W+1:2];
    assign lat_tag  = mem.mem_addr[31:IDX_W+2];

    assign unused_addr_bits = ^{aluoutm[1:0], mem.mem_addr[1:0]};

    // The array resets to zero, so rdm is never X and reads as 0 in reset.
    assign rdm = data[idx];

    // In IDLE the stall must be raised in the same cycle the access appears,
    // hence combinational. Gating with reset drops it immediately when reset
    // is asserted even if the M-stage inputs are still presenting an access.
    always_comb begin
        stallm = 1'b0;
        if (reset) begin
            case (state)
                IDLE:        stallm = is_store || (is_load && !hit);
                FILL, WRITE: stallm = 1'b1;
                default:     stallm = 1'b0;
            endcase
        end
    end

    // Controller FSM with registered handshake outputs and the tag/data array.
    // store_hit remembers the hit result seen in IDLE, because the array is
    // only updated on a store that hit at evaluation time (no allocate).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            store_hit     <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                valid[i] <= 1'b0;
                tags[i]  <= '0;
                data[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (is_store || (is_load && !hit)) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= is_store;
                        mem.mem_addr  <= {aluoutm[31:2], 2'b00};
                        mem.mem_wdata <= writedatam;
                        store_hit     <= hit;
                        state         <= is_store ? WRITE : FILL;
                    end
                end
                FILL: begin
                    if (mem.mem_ready) begin
                        data[lat_idx]  <= mem.mem_rdata;
                        valid[lat_idx] <= 1'b1;
                        tags[lat_idx]  <= lat_tag;
                        mem.mem_req    <= 1'b0;
                        mem.mem_we     <= 1'b0;
                        state          <= DONE;
                    end
                end
                WRITE: begin
                    if (mem.mem_ready) begin
                        if (store_hit) begin
                            data[lat_idx] <= mem.mem_wdata;
                        end
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // A load miss in IDLE is exactly the IDLE->FILL transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hitcount  <= '0;
            misscount <= '0;
        end else if (state == IDLE) begin
            if (is_load && hit) begin
                hitcount <= hitcount + 32'd1;
            end
            if (is_load && !hit) begin
                misscount <= misscount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl
// Self-checking bench for dcache_ctrl (LINES = 16). Directed accesses push
// their expected memory request and retirement (stall length, load data)
// into queues; a monitor process pops and compares whenever the DUT issues a
// request, retires an access, or is put into reset. A small memory model
// answers each request with mem_ready in the k-th request cycle.
// With DCACHE_STATS_EN defined the hit/miss counters are also checked.
module tb_dcache_ctrl;

    typedef struct {
        bit          is_load;
        int          stalls;
        logic [31:0] rdata;
    } retire_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        reset;
    logic        memtoregm;
    logic        memwritem;
    logic [31:0] aluoutm;
    logic [31:0] writedatam;
    logic [31:0] rdm;
    logic        stallm;
`ifdef DCACHE_STATS_EN
    logic [31:0] hitcount;
    logic [31:0] misscount;
`endif

    dcache_ctrl_if mif ();

    dcache_ctrl #(.LINES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (mif),
        .memtoregm  (memtoregm),
        .memwritem  (memwritem),
        .aluoutm    (aluoutm),
        .writedatam (writedatam),
        .rdm        (rdm),
`ifdef DCACHE_STATS_EN
        .hitcount   (hitcount),
        .misscount  (misscount),
`endif
        .stallm     (stallm)
    );

    retire_t     retire_q[$];
    req_t        req_q[$];
    int          rst_q[$];

    int          n_checks;
    int          n_fail;
    int          timeouts;
    bit          tb_done;
    int          mem_k;
    logic [31:0] mem_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: mem_ready in the mem_k-th cycle that mem_req is high.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'hBAD0BAD0;
        forever begin
            @(negedge clk);
            if (reset && mif.mem_req) begin
                cnt++;
                mif.mem_ready = (cnt == mem_k);
                mif.mem_rdata = (cnt == mem_k) ? mem_data : 32'hBAD0BAD0;
            end else begin
                cnt = 0;
                mif.mem_ready = 1'b0;
                mif.mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: sole owner of the check counters.
    initial begin : monitor
        int      stall_cnt;
        bit      prev_req;
        retire_t r;
        req_t    q;
        stall_cnt = 0;
        prev_req  = 1'b0;
        n_checks  = 0;
        n_fail    = 0;
        forever begin
            @(negedge clk or negedge reset or posedge tb_done);
            if (tb_done) begin
                check_output("timeouts", 32'(timeouts), 32'd0);
                check_output("retire_q_left", 32'(retire_q.size()), 32'd0);
                check_output("req_q_left", 32'(req_q.size()), 32'd0);
`ifdef DCACHE_STATS_EN
                check_output("hitcount", hitcount, 32'd2);
                check_output("misscount", misscount, 32'd2);
`endif
                $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
                $finish;
            end else if (!reset) begin
                stall_cnt = 0;
                prev_req  = 1'b0;
                if (rst_q.size() != 0) begin
                    void'(rst_q.pop_front());
                    #1;
                    check_output("rst_stallm",    32'(stallm),        32'd0);
                    check_output("rst_mem_req",   32'(mif.mem_req),   32'd0);
                    check_output("rst_mem_we",    32'(mif.mem_we),    32'd0);
                    check_output("rst_mem_addr",  mif.mem_addr,       32'd0);
                    check_output("rst_mem_wdata", mif.mem_wdata,      32'd0);
                    check_output("rst_rdm",       rdm,                32'd0);
                end
            end else begin
                if (mif.mem_req && !prev_req) begin
                    check_output("req_expected", 32'(req_q.size() != 0), 32'd1);
                    if (req_q.size() != 0) begin
                        q = req_q.pop_front();
                        check_output("req_we", 32'(mif.mem_we), 32'(q.we));
                        check_output("req_addr", mif.mem_addr, q.addr);
                        if (q.we) begin
                            check_output("req_wdata", mif.mem_wdata, q.wdata);
                        end
                    end
                end
                prev_req = mif.mem_req;
                if (memtoregm || memwritem) begin
                    if (stallm) begin
                        stall_cnt++;
                    end else begin
                        check_output("retire_expected", 32'(retire_q.size() != 0), 32'd1);
                        if (retire_q.size() != 0) begin
                            r = retire_q.pop_front();
                            check_output("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
                            if (r.is_load) begin
                                check_output("rdm", rdm, r.rdata);
                            end
                        end
                        stall_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_q.push_back(1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One M-stage access, held until it retires (stallm low), then removed.
    task automatic apply_stimulus(input bit ld, input bit st, input logic [31:0] addr,
                                  input logic [31:0] wdata, input bit exp_hit, input int k,
                                  input logic [31:0] mdata, input logic [31:0] exp_rdata);
        retire_t r;
        req_t    q;
        bit      done;
        r.is_load = ld && !st;
        r.rdata   = exp_rdata;
        if (st || !exp_hit) begin
            q.we    = st;
            q.addr  = addr;
            q.wdata = wdata;
            req_q.push_back(q);
            r.stalls = 1 + k;
        end else begin
            r.stalls = 0;
        end
        retire_q.push_back(r);
        mem_k      = k;
        mem_data   = mdata;
        memtoregm  = ld;
        memwritem  = st;
        aluoutm    = addr;
        writedatam = wdata;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!stallm) done = 1'b1;
        end
        if (!done) begin
            timeouts++;
            $display("[TB] timeout waiting for access to 0x%h to retire", addr);
        end
        @(posedge clk);
        #1;
        memtoregm  = 1'b0;
        memwritem  = 1'b0;
        aluoutm    = 32'd0;
        writedatam = 32'd0;
    endtask

    initial begin : stimulus
        req_t q;
        reset      = 1'b1;
        memtoregm  = 1'b0;
        memwritem  = 1'b0;
        aluoutm    = 32'd0;
        writedatam = 32'd0;
        mem_k      = 1;
        mem_data   = 32'd0;
        timeouts   = 0;
        tb_done    = 1'b0;
        #1;
        do_reset();

        $display("[TB] cold miss, hit, conflict misses");
        apply_stimulus(1, 0, 32'h40,  32'h0, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF);
        apply_stimulus(1, 0, 32'h40,  32'h0, 1, 0, 32'h0,        32'hDEADBEEF);
        apply_stimulus(1, 0, 32'h80,  32'h0, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D);
        apply_stimulus(1, 0, 32'h40,  32'h0, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF);

        $display("[TB] store hit, store miss (no allocate)");
        apply_stimulus(0, 1, 32'h40,  32'h12345678, 0, 2, 32'h0, 32'h0);
        apply_stimulus(1, 0, 32'h40,  32'h0, 1, 0, 32'h0,        32'h12345678);
        apply_stimulus(0, 1, 32'h100, 32'hA5A5A5A5, 0, 1, 32'h0, 32'h0);
        apply_stimulus(1, 0, 32'h40,  32'h0, 1, 0, 32'h0,        32'h12345678);
        apply_stimulus(1, 0, 32'h100, 32'h0, 0, 1, 32'h0BADF00D, 32'h0BADF00D);

        $display("[TB] second index, load+store together acts as store");
        apply_stimulus(1, 0, 32'h44,  32'h0, 0, 1, 32'h11112222, 32'h11112222);
        apply_stimulus(1, 1, 32'h44,  32'h55556666, 0, 3, 32'h0, 32'h0);
        apply_stimulus(1, 0, 32'h44,  32'h0, 1, 0, 32'h0,        32'h55556666);

        $display("[TB] reset during FILL");
        q.we = 1'b0;
        q.addr = 32'h200;
        q.wdata = 32'h0;
        req_q.push_back(q);
        mem_k     = 20;
        mem_data  = 32'hFFFF0000;
        memtoregm = 1'b1;
        aluoutm   = 32'h200;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_q.push_back(1);
        reset = 1'b0;
        #3;
        memtoregm = 1'b0;
        aluoutm   = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1, 0, 32'h44,  32'h0, 0, 1, 32'h77778888, 32'h77778888);

        $display("[TB] statistics sequence");
        do_reset();
        apply_stimulus(1, 0, 32'h40,  32'h0, 0, 1, 32'h00000001, 32'h00000001);
        apply_stimulus(1, 0, 32'h40,  32'h0, 1, 0, 32'h0,        32'h00000001);
        apply_stimulus(1, 0, 32'h40,  32'h0, 1, 0, 32'h0,        32'h00000001);
        apply_stimulus(0, 1, 32'h40,  32'h00000002, 0, 1, 32'h0, 32'h0);
        apply_stimulus(1, 0, 32'h80,  32'h0, 0, 1, 32'h00000003, 32'h00000003);

        repeat (2) @(posedge clk);
        #1;
        tb_done = 1'b1;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
